mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 8, RAM address width in bits.
REQ-002 Parameter DATA_W, 8, RAM data width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 f_req  input  1  fetch read request; held with f_addr stable until f_gnt.
REQ-006 f_addr  input  ADDR_W  fetch address.
REQ-007 f_gnt  output  1  one-cycle pulse: fetch request accepted this cycle.
REQ-008 f_rvalid  output  1  one-cycle pulse: f_rdata valid.
REQ-009 f_rdata  output  DATA_W  fetch read data, registered.
REQ-010 d_req  input  1  data request; held with d_we/d_addr/d_wdata stable until d_gnt.
REQ-011 d_we  input  1  0 read, 1 write.
REQ-012 d_addr  input  ADDR_W  data address.
REQ-013 d_wdata  input  DATA_W  write data.
REQ-014 d_gnt  output  1  one-cycle pulse: data request accepted this cycle.
REQ-015 d_done  output  1  one-cycle pulse: data access complete; d_rdata valid if read.
REQ-016 d_rdata  output  DATA_W  data read data, registered.
REQ-017 ram_en  output  1  RAM enable (feeds RAM clock gate).
REQ-018 ram_addr  output  ADDR_W  RAM address.
REQ-019 ram_wdata  output  DATA_W  RAM write data.
REQ-020 ram_r_w  output  1  0 read, 1 write.
REQ-021 ram_rdata  input  DATA_W  RAM read data; registered in RAM, valid the cycle after the enabled edge.
REQ-022 busy  output  1  high whenever state is not IDLE.

Function
REQ-023 FSM states IDLE, ACCESS, CAPTURE, RESP; one state per cycle, no stalls.
REQ-024 IDLE: if any req high, select one requester, assert its gnt combinationally that cycle, latch its addr/we/wdata and owner ID, go ACCESS; else stay IDLE.
REQ-025 ACCESS: ram_en=1, ram_addr/ram_wdata/ram_r_w driven from latched registers; fetch always drives ram_r_w=0; go CAPTURE.
REQ-026 CAPTURE: ram_en=0; on read, capture ram_rdata into owner's rdata register at cycle end; go RESP.
REQ-027 RESP: pulse owner's f_rvalid or d_done; the RESP cycle is also treated as IDLE for arbitration (gnt may assert in RESP), so back-to-back throughput is one access per 3 cycles.
REQ-028 Latency: gnt in cycle N -> ram_en in N+1 -> rvalid/done in N+3, identical for reads and writes.
REQ-029 Write: d_rdata unchanged; d_done pulses in RESP.
REQ-030 Non-owner's rdata register never changes.
REQ-031 ram_addr, ram_wdata, ram_r_w SHALL be 0 whenever ram_en=0.
REQ-032 Request dropped before gnt is withdrawn with no side effect; req changes after gnt are ignored until next arbitration.
REQ-033 At most one of f_gnt/d_gnt, and at most one of f_rvalid/d_done, high in any cycle.
REQ-034 Single requester active: it is granted regardless of priority state.

Reset
REQ-035 rst_n low at a clock edge: state=IDLE, all outputs 0, rdata registers 0, latched request cleared, last-grant = fetch.
REQ-036 Reset mid-transaction discards it: no rvalid/done pulse, ram_en 0 from next cycle.
REQ-037 No gnt is issued in a cycle where rst_n is low.

Configuration
REQ-038 Macro MEM_ARB_ROUND_ROBIN_EN defined: simultaneous requests resolved round-robin; the requester not granted last wins; last-grant register updated on each gnt.
REQ-039 Macro undefined: fixed priority, data wins over fetch; no last-grant register.

Verification
REQ-040 Fetch read, f_addr=0x10, RAM 0x10=0xA5: f_gnt at N, ram_en at N+1 with ram_addr=0x10 ram_r_w=0, f_rvalid at N+3 with f_rdata=0xA5.
REQ-041 Data write d_addr=0x20 d_wdata=0x5A then data read 0x20: ram_r_w=1 on write ACCESS, d_done at N+3, read returns d_rdata=0x5A, d_rdata unchanged after write.
REQ-042 f_req and d_req held high for 4 grants: with MEM_ARB_ROUND_ROBIN_EN grants D,F,D,F every 3 cycles; without, D,D,D,D and f_gnt never asserts.
REQ-043 Reset asserted during CAPTURE of a read: no f_rvalid/d_done, all outputs 0 next cycle, next request granted normally with round-robin favoring data.
REQ-044 Request raised then dropped during a competing access: never granted, no RAM access for it, busy low after the competing RESP.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch/data) arbiter in front of a single-port synchronous RAM.
// Each access takes four states: IDLE/RESP (arbitrate), ACCESS (RAM enabled), CAPTURE (read data back).
// Optional macro MEM_ARB_ROUND_ROBIN_EN: round-robin arbitration on simultaneous requests;
// when undefined, data always wins over fetch.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_r_w,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              own_d_q;
    logic              we_q;
    logic              pick_d;
    logic              grant;
    logic              arb_ok;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic              f_rvalid_q;
    logic              d_done_q;
    logic [DATA_W-1:0] f_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              ram_en_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic              ram_r_w_q;
    logic              busy_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              last_d_q;
`endif

    // Arbitration: grants are combinational and only issued in IDLE or RESP out of reset
    always_comb begin
        arb_ok = rst_n && ((state_q == IDLE) || (state_q == RESP));
`ifdef MEM_ARB_ROUND_ROBIN_EN
        pick_d = d_req && (!f_req || !last_d_q);
`else
        pick_d = d_req;
`endif
        d_gnt     = arb_ok && pick_d;
        f_gnt     = arb_ok && f_req && !pick_d;
        grant     = f_gnt || d_gnt;
        sel_addr  = pick_d ? d_addr : f_addr;
        sel_wdata = pick_d ? d_wdata : DATA_W'(0);
        sel_we    = pick_d && d_we;
    end

    // Next-state logic: fixed three-cycle walk after a grant, RESP may chain into a new grant
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = grant ? ACCESS : IDLE;
            ACCESS:  state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    state_d = grant ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, latched request, RAM drive and response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            own_d_q     <= 1'b0;
            we_q        <= 1'b0;
            f_rvalid_q  <= 1'b0;
            d_done_q    <= 1'b0;
            f_rdata_q   <= '0;
            d_rdata_q   <= '0;
            ram_en_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_r_w_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_d_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            if (grant) begin
                own_d_q <= d_gnt;
                we_q    <= sel_we;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                last_d_q <= d_gnt;
`endif
            end
            // RAM drive lives only for the ACCESS cycle and is zero otherwise
            ram_en_q    <= grant;
            ram_addr_q  <= grant ? sel_addr : ADDR_W'(0);
            ram_wdata_q <= grant ? sel_wdata : DATA_W'(0);
            ram_r_w_q   <= grant && sel_we;
            if ((state_q == CAPTURE) && !we_q) begin
                if (own_d_q) d_rdata_q <= ram_rdata;
                else         f_rdata_q <= ram_rdata;
            end
            f_rvalid_q <= (state_q == CAPTURE) && !own_d_q;
            d_done_q   <= (state_q == CAPTURE) && own_d_q;
        end
    end

    assign f_rvalid  = f_rvalid_q;
    assign d_done    = d_done_q;
    assign f_rdata   = f_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign ram_en    = ram_en_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_r_w   = ram_r_w_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by random traffic, checked every cycle
// against a transaction-timeline reference model (grant at N, RAM at N+1, response at N+3).
module tb_mem_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, f_req, f_gnt, f_rvalid, d_req, d_we, d_gnt, d_done;
    logic          ram_en, ram_r_w, busy;
    logic [AW-1:0] f_addr, d_addr, ram_addr;
    logic [DW-1:0] f_rdata, d_wdata, d_rdata, ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_r_w(ram_r_w),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return a ^ 8'hB5;
    endfunction

    // Environment RAM: registered read, contents start from init_val
    logic [7:0] mem   [256];
    bit         mem_w [256];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_r_w) begin
                mem[ram_addr]   <= ram_wdata;
                mem_w[ram_addr] <= 1'b1;
            end else begin
                ram_rdata <= mem_w[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
            end
        end
    end

    int errors = 0;
    int checks = 0;

    // Stimulus drive values
    bit         rst_v = 1'b0, fr = 1'b0, dr = 1'b0, dwe = 1'b0;
    logic [7:0] fa = '0, da = '0, dwd = '0;
    bit         saw_fg, saw_dg;

    // Reference model state
    int         cyc_n = 0;
    int         last_g = -100;
    bit         last_win_d = 1'b0;
    bit         chk_on = 1'b0;
    logic [7:0] ref_mem [256];
    bit         ref_w   [256];
    bit         e_en [8], e_rw [8], e_frv [8], e_ddn [8], e_drd [8];
    logic [7:0] e_addr [8], e_wd [8], e_rd [8];
    logic [7:0] exp_f_rdata = '0, exp_d_rdata = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    task automatic clr_slot(input int k);
        e_en[k] = 0; e_rw[k] = 0; e_frv[k] = 0; e_ddn[k] = 0; e_drd[k] = 0;
        e_addr[k] = '0; e_wd[k] = '0; e_rd[k] = '0;
    endtask

    // One clock cycle: drive at negedge, compare shortly after, then advance the model
    task automatic cycle();
        int         k, k1, k3;
        bit         can_g, win_d, g;
        logic [7:0] a;
        @(negedge clk);
        rst_n = rst_v; f_req = fr; f_addr = fa;
        d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
        #2;
        k = cyc_n % 8;
        if (e_frv[k]) exp_f_rdata = e_rd[k];
        if (e_ddn[k] && e_drd[k]) exp_d_rdata = e_rd[k];
        can_g = rst_v && (cyc_n >= last_g + 3);
        win_d = (fr && dr) ? (RR ? !last_win_d : 1'b1) : dr;
        g     = can_g && (fr || dr);
        if (chk_on) begin
            chk("f_gnt",     32'(f_gnt),     32'(g && !win_d));
            chk("d_gnt",     32'(d_gnt),     32'(g && win_d));
            chk("ram_en",    32'(ram_en),    32'(e_en[k]));
            chk("ram_addr",  32'(ram_addr),  32'(e_addr[k]));
            chk("ram_wdata", 32'(ram_wdata), 32'(e_wd[k]));
            chk("ram_r_w",   32'(ram_r_w),   32'(e_rw[k]));
            chk("f_rvalid",  32'(f_rvalid),  32'(e_frv[k]));
            chk("d_done",    32'(d_done),    32'(e_ddn[k]));
            chk("f_rdata",   32'(f_rdata),   32'(exp_f_rdata));
            chk("d_rdata",   32'(d_rdata),   32'(exp_d_rdata));
            chk("busy",      32'(busy),      32'(cyc_n > last_g && cyc_n <= last_g + 3));
        end
        clr_slot(k);
        if (!rst_v) begin
            for (int i = 0; i < 8; i++) clr_slot(i);
            exp_f_rdata = '0; exp_d_rdata = '0;
            last_g = -100; last_win_d = 1'b0; chk_on = 1'b1;
        end else if (g) begin
            k1 = (cyc_n + 1) % 8;
            k3 = (cyc_n + 3) % 8;
            a  = win_d ? da : fa;
            e_en[k1] = 1'b1; e_addr[k1] = a;
            e_wd[k1] = win_d ? dwd : 8'h00;
            e_rw[k1] = win_d && dwe;
            e_frv[k3] = !win_d; e_ddn[k3] = win_d; e_drd[k3] = win_d && !dwe;
            e_rd[k3]  = ref_w[a] ? ref_mem[a] : init_val(a);
            if (win_d && dwe) begin ref_mem[a] = dwd; ref_w[a] = 1'b1; end
            last_g = cyc_n; last_win_d = win_d;
        end
        saw_fg = f_gnt; saw_dg = d_gnt;
        cyc_n++;
    endtask

    task automatic do_reset();
        rst_v = 1'b0; cycle(); rst_v = 1'b1;
    endtask

    task automatic wait_gnt(input bit is_d);
        bit got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            cycle();
            got = is_d ? saw_dg : saw_fg;
        end
        chk(is_d ? "d_gnt_timeout" : "f_gnt_timeout", 32'(got), 32'd1);
        if (is_d) dr = 1'b0; else fr = 1'b0;
    endtask

    initial begin
        int         n_gnt, last_c, n_fg;
        bit         seq_d [4];
        int         seq_c [4];
        for (int i = 0; i < 256; i++) ref_w[i] = 1'b0;
        for (int i = 0; i < 8; i++) clr_slot(i);

        cycle();
        do_reset();
        repeat (2) cycle();

        // Fetch read of 0x10 (RAM holds 0xA5)
        fa = 8'h10; fr = 1'b1;
        wait_gnt(1'b0);
        cycle();
        chk("r040_ram_en", 32'(ram_en), 32'd1);
        chk("r040_ram_addr", 32'(ram_addr), 32'h10);
        chk("r040_ram_r_w", 32'(ram_r_w), 32'd0);
        cycle(); cycle();
        chk("r040_f_rvalid", 32'(f_rvalid), 32'd1);
        chk("r040_f_rdata", 32'(f_rdata), 32'hA5);
        repeat (2) cycle();

        // Data write 0x20=0x5A, then read it back
        da = 8'h20; dwd = 8'h5A; dwe = 1'b1; dr = 1'b1;
        wait_gnt(1'b1);
        cycle();
        chk("r041_ram_r_w", 32'(ram_r_w), 32'd1);
        chk("r041_ram_wdata", 32'(ram_wdata), 32'h5A);
        cycle(); cycle();
        chk("r041_wr_done", 32'(d_done), 32'd1);
        chk("r041_wr_rdata_unchanged", 32'(d_rdata), 32'h00);
        dwe = 1'b0; dwd = 8'h00; dr = 1'b1;
        wait_gnt(1'b1);
        repeat (3) cycle();
        chk("r041_rd_done", 32'(d_done), 32'd1);
        chk("r041_rd_data", 32'(d_rdata), 32'h5A);
        repeat (2) cycle();

        // Both requesters held for four grants
        do_reset();
        fa = 8'h01; da = 8'h02; dwe = 1'b0; fr = 1'b1; dr = 1'b1;
        n_gnt = 0;
        for (int i = 0; i < 30 && n_gnt < 4; i++) begin
            cycle();
            if (saw_fg || saw_dg) begin
                seq_d[n_gnt] = saw_dg; seq_c[n_gnt] = cyc_n; n_gnt++;
            end
        end
        fr = 1'b0; dr = 1'b0;
        chk("r042_grant_count", 32'(n_gnt), 32'd4);
        for (int i = 0; i < n_gnt; i++) begin
            chk("r042_grant_owner", 32'(seq_d[i]), 32'(RR ? (i % 2 == 0) : 1'b1));
            if (i > 0) chk("r042_grant_spacing", 32'(seq_c[i] - seq_c[i-1]), 32'd3);
        end
        repeat (4) cycle();

        // Reset during CAPTURE of a fetch read, then a contended request
        fa = 8'h07; fr = 1'b1;
        wait_gnt(1'b0);
        cycle();
        rst_v = 1'b0; cycle(); rst_v = 1'b1;
        fr = 1'b1; dr = 1'b1; da = 8'h08;
        cycle();
        chk("r043_no_rvalid", 32'(f_rvalid), 32'd0);
        chk("r043_busy_low", 32'(busy), 32'd0);
        chk("r043_d_wins", 32'(d_gnt), 32'd1);
        chk("r043_f_loses", 32'(f_gnt), 32'd0);
        dr = 1'b0;
        wait_gnt(1'b0);
        repeat (4) cycle();

        // Fetch raised and withdrawn during a data access
        da = 8'h30; dwd = 8'h77; dwe = 1'b1; dr = 1'b1;
        wait_gnt(1'b1);
        dwe = 1'b0;
        fa = 8'h33; fr = 1'b1;
        n_fg = 0;
        cycle(); n_fg += int'(saw_fg);
        fr = 1'b0;
        repeat (3) begin cycle(); n_fg += int'(saw_fg); end
        chk("r044_never_granted", 32'(n_fg), 32'd0);
        chk("r044_busy_low", 32'(busy), 32'd0);
        repeat (2) cycle();

        // Random traffic with occasional withdrawals and resets
        for (int i = 0; i < 3000; i++) begin
            if (fr) begin
                if (saw_fg || $urandom_range(0, 15) == 0) fr = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                fr = 1'b1; fa = 8'($urandom_range(0, 15));
            end
            if (dr) begin
                if (saw_dg || $urandom_range(0, 15) == 0) dr = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                dr = 1'b1; da = 8'($urandom_range(0, 15));
                dwe = 1'($urandom_range(0, 1)); dwd = 8'($urandom_range(0, 255));
            end
            rst_v = ($urandom_range(0, 199) != 0);
            cycle();
        end
        rst_v = 1'b1; fr = 1'b0; dr = 1'b0;
        repeat (5) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
